avalon_mm_arbiter_2to1: RTL and testbench
=========================================

// Module: avalon_mm_arbiter_2to1
// PURPOSE
//  Round-robin arbiter that shares one Avalon-MM slave port between two Avalon-MM masters.
//  The slave port is the avalon_export_0 avs_s0 window: 2-bit address, 32-bit data, waitrequest.
//  The masters are Avalon_Simple_Master_0 and a second requester.
//  Sits in the Qsys top level between the masters and the exported slave. Exactly one master owns the slave per transfer.
// PARAMETERS
//  ADDR_W          2    slave/master word-address width
//  DATA_W          32   read/write data width
//  TIMEOUT_CYCLES  256  consecutive slave-waitrequest cycles before abort (ARB_TIMEOUT_EN only)
// PORTS
//  clk_clk          in   1       single clock, all logic rising-edge
//  reset_reset      in   1       synchronous, active-high reset
//  mN_address       in   ADDR_W  master N address (N=0,1)
//  mN_read          in   1       master N read request
//  mN_write         in   1       master N write request
//  mN_writedata     in   DATA_W  master N write data
//  mN_readdata      out  DATA_W  master N read data, valid when mN_waitrequest low on a read
//  mN_waitrequest   out  1       master N stall
//  s_address        out  ADDR_W  to slave
//  s_read/s_write   out  1       to slave
//  s_writedata      out  DATA_W  to slave
//  s_readdata       in   DATA_W  from slave, zero-wait-state fixed latency
//  s_waitrequest    in   1       from slave
//  grant            out  2       one-hot current owner; 00 when idle
//  timeout_err      out  1       one-cycle abort pulse; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//  - FSM states: IDLE, GNT0, GNT1. Request: reqN = mN_read | mN_write.
//  - Reset state:
//    - state=IDLE; last_grant=1, so m0 wins the first tie.
//    - s_read=s_write=0; s_address/s_writedata=0.
//    - m0/m1_waitrequest=1; mN_readdata=0; grant=00; timeout_err=0.
//  - IDLE: all waitrequests high; slave read/write low.
//    - Single request -> GNTn next cycle.
//    - Both requesting -> grant the master that is not last_grant.
//  - GNTn: mN address/writedata/read/write drive s_* combinationally.
//    - s_read = mN_read & ~mN_write; write wins on a protocol violation.
//    - mN_waitrequest = s_waitrequest; mN_readdata = s_readdata.
//    - Other master: waitrequest=1, readdata=0.
//  - Completion: in GNTn with (s_read|s_write) & ~s_waitrequest.
//    - Set last_grant=n; go to IDLE next cycle.
//    - One mandatory idle cycle between transfers.
//  - Latency: request at cycle t in IDLE -> command on slave at t+1.
//    - Earliest data/ack at t+1; mN_waitrequest high at t.
//  - Master drops reqN while in GNTn (violation): return to IDLE next cycle; last_grant unchanged.
//  - Requests arriving during a grant are held off by waitrequest and arbitrated in the next IDLE.
//  - Reset mid-transfer: next cycle is the reset state; the in-flight transfer is abandoned and not retried.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined: wait counter clears on entering GNTn.
//    - Counter increments every GNTn cycle with s_waitrequest high.
//    - At TIMEOUT_CYCLES the cycle is aborted:
//      - s_read/s_write forced 0; mN_waitrequest forced 0.
//      - mN_readdata = 32'hDEAD_BEEF; timeout_err pulses 1.
//      - state -> IDLE; last_grant=n.
//  - ARB_TIMEOUT_EN undefined: no counter; a stalled slave holds the grant indefinitely; timeout_err=0.
// STRUCTURE
//  - Package avalon_arb_pkg:
//    - arb_state_t enum {IDLE,GNT0,GNT1}
//    - TIMEOUT_RDATA=32'hDEAD_BEEF
//    - GRANT_NONE/GRANT_M0/GRANT_M1 one-hot constants
//  - Sub-module rr_pick2: combinational (req[1:0], last_grant) -> winner; instantiated once.
//  - Top module holds the FSM, last_grant register, mux and optional counter.
// TESTING
//  1. m0 read addr 2; slave waitrequest=0, s_readdata=0x12345678.
//     -> grant=01 at t+1; m0_waitrequest low at t+1 with m0_readdata=0x12345678; IDLE at t+2.
//  2. m0 and m1 request in the same cycle after reset.
//     -> m0 served first, then m1; a following simultaneous pair is served m0 then m1.
//  3. m1 write addr 1 data 0xA5A5A5A5; slave stalls 5 cycles.
//     -> s_writedata stable for 6 grant cycles; m1_waitrequest high 5 cycles; m0_waitrequest high throughout.
//  4. reset_reset pulsed during GNT0 with slave stalling.
//     -> next cycle grant=00, s_read=s_write=0, both waitrequests=1.
//  5. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks a m0 read.
//     -> after 8 stalled cycles m0 gets 0xDEADBEEF, timeout_err one-cycle pulse, m1 then granted.
//     -> Without the macro the grant persists.
//  6. m0 drops read mid-stall.
//     -> IDLE next cycle; a pending m0 request is granted before m1.

Source files
------------

// File: rtl/avalon_mm_arbiter_2to1_pkg.sv
// Shared types and constants for the two-master Avalon-MM round-robin arbiter.
// Holds the FSM state enum, the one-hot grant encodings and the abort read-data pattern.
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Maps an FSM state to the one-hot grant vector seen outside the block.
  function automatic logic [1:0] grant_onehot(arb_state_t st);
    logic [1:0] g;
    g = GRANT_NONE;
    case (st)
      GNT0:    g = GRANT_M0;
      GNT1:    g = GRANT_M1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/avalon_mm_arbiter_2to1_if.sv
// Avalon-MM word-addressed bus bundle (address/read/write/writedata/readdata/waitrequest).
// The master modport is the side that issues commands; the slave modport answers them.
interface avalon_mm_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata,
    output waitrequest
  );

endinterface

// File: rtl/avalon_mm_arbiter_2to1_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the
// requester that was not served last. Purely combinational.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/avalon_mm_arbiter_2to1.sv
// Round-robin arbiter sharing one Avalon-MM slave between two masters.
// Optional wait-state abort is enabled by defining ARB_TIMEOUT_EN.
module avalon_mm_arbiter_2to1
  import avalon_arb_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  avalon_mm_if.slave  m0,
  avalon_mm_if.slave  m1,
  avalon_mm_if.master s,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;

  logic [1:0] req;
  logic       pick_valid;
  logic       pick_winner;
  logic       granted;
  logic       sel;
  logic       timeout_hit;

  logic [ADDR_W-1:0] sel_address;
  logic [DATA_W-1:0] sel_writedata;
  logic              sel_read;
  logic              sel_write;
  logic              sel_req;

  logic [ADDR_W-1:0] s_address_mux;
  logic [DATA_W-1:0] s_writedata_mux;
  logic              s_read_mux;
  logic              s_write_mux;
  logic              m0_waitrequest_mux;
  logic              m1_waitrequest_mux;
  logic [DATA_W-1:0] m0_readdata_mux;
  logic [DATA_W-1:0] m1_readdata_mux;
  logic              timeout_err_mux;
  logic              done;

  assign req     = {m1.read | m1.write, m0.read | m0.write};
  assign granted = (state_q != IDLE);
  assign sel     = (state_q == GNT1);

  rr_pick2 u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_comb begin
    sel_address   = m0.address;
    sel_writedata = m0.writedata;
    sel_read      = m0.read;
    sel_write     = m0.write;
    sel_req       = req[0];
    if (sel) begin
      sel_address   = m1.address;
      sel_writedata = m1.writedata;
      sel_read      = m1.read;
      sel_write     = m1.write;
      sel_req       = req[1];
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Counter sits at zero in IDLE so every new grant starts a fresh stall window.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!granted) begin
      wait_cnt_d = '0;
    end else if (s.waitrequest && !timeout_hit) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout_hit = granted && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // The owner sees the slave directly; an abort fakes a completed transfer instead.
  always_comb begin
    s_address_mux      = '0;
    s_writedata_mux    = '0;
    s_read_mux         = 1'b0;
    s_write_mux        = 1'b0;
    m0_waitrequest_mux = 1'b1;
    m1_waitrequest_mux = 1'b1;
    m0_readdata_mux    = '0;
    m1_readdata_mux    = '0;
    timeout_err_mux    = 1'b0;
    if (granted) begin
      s_address_mux   = sel_address;
      s_writedata_mux = sel_writedata;
      s_write_mux     = sel_write & ~timeout_hit;
      s_read_mux      = sel_read & ~sel_write & ~timeout_hit;
      timeout_err_mux = timeout_hit;
      if (sel) begin
        m1_waitrequest_mux = s.waitrequest & ~timeout_hit;
        m1_readdata_mux    = timeout_hit ? DATA_W'(TIMEOUT_RDATA) : s.readdata;
      end else begin
        m0_waitrequest_mux = s.waitrequest & ~timeout_hit;
        m0_readdata_mux    = timeout_hit ? DATA_W'(TIMEOUT_RDATA) : s.readdata;
      end
    end
  end

  assign done = (s_read_mux | s_write_mux) & ~s.waitrequest;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = pick_winner ? GNT1 : GNT0;
        end
      end
      GNT0, GNT1: begin
        // A withdrawn request releases the bus without counting as a service.
        if (!sel_req) begin
          state_d = IDLE;
        end else if (timeout_hit || done) begin
          state_d      = IDLE;
          last_grant_d = sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign s.address      = s_address_mux;
  assign s.writedata    = s_writedata_mux;
  assign s.read         = s_read_mux;
  assign s.write        = s_write_mux;
  assign m0.waitrequest = m0_waitrequest_mux;
  assign m1.waitrequest = m1_waitrequest_mux;
  assign m0.readdata    = m0_readdata_mux;
  assign m1.readdata    = m1_readdata_mux;
  assign grant          = grant_onehot(state_q);
  assign timeout_err    = timeout_err_mux;

endmodule

// File: tb/tb_avalon_mm_arbiter_2to1.sv
// Directed bench for avalon_mm_arbiter_2to1: each applyStimulus call is one clock
// cycle of inputs, followed by checks of the combinational outputs in that cycle.
module tb_avalon_mm_arbiter_2to1;

  logic       clk_clk;
  logic       reset_reset;
  logic [1:0] grant;
  logic       timeout_err;

  int n_cmp;
  int n_fail;

  avalon_mm_if #(.ADDR_W(2), .DATA_W(32)) m0_if ();
  avalon_mm_if #(.ADDR_W(2), .DATA_W(32)) m1_if ();
  avalon_mm_if #(.ADDR_W(2), .DATA_W(32)) s_if ();

`ifdef ARB_TIMEOUT_EN
  avalon_mm_arbiter_2to1 #(.ADDR_W(2), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
`else
  avalon_mm_arbiter_2to1 #(.ADDR_W(2), .DATA_W(32)) dut (
`endif
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // One cycle: inputs change 1ns after the rising edge and settle before checks.
  task automatic applyStimulus(input logic rst,
                               input logic m0r, input logic m0w, input logic [1:0] m0a, input logic [31:0] m0d,
                               input logic m1r, input logic m1w, input logic [1:0] m1a, input logic [31:0] m1d,
                               input logic sw, input logic [31:0] srd);
    @(posedge clk_clk);
    #1;
    reset_reset        = rst;
    m0_if.read         = m0r;
    m0_if.write        = m0w;
    m0_if.address      = m0a;
    m0_if.writedata    = m0d;
    m1_if.read         = m1r;
    m1_if.write        = m1w;
    m1_if.address      = m1a;
    m1_if.writedata    = m1d;
    s_if.waitrequest   = sw;
    s_if.readdata      = srd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".grant"}, 32'(grant), 32'h0);
    checkOutput({tag, ".s_read"}, 32'(s_if.read), 32'h0);
    checkOutput({tag, ".s_write"}, 32'(s_if.write), 32'h0);
    checkOutput({tag, ".m0_wait"}, 32'(m0_if.waitrequest), 32'h1);
    checkOutput({tag, ".m1_wait"}, 32'(m1_if.waitrequest), 32'h1);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset_reset = 1'b1;
    m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = '0; m0_if.writedata = '0;
    m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0; m1_if.writedata = '0;
    s_if.waitrequest = 1'b0; s_if.readdata = '0;

    // Reset state
    applyStimulus(1, 0,0,2'd0,32'h0, 0,0,2'd0,32'h0, 0, 32'h0);
    applyStimulus(1, 0,0,2'd0,32'h0, 0,0,2'd0,32'h0, 0, 32'h0);
    checkIdle("rst");
    checkOutput("rst.s_address", 32'(s_if.address), 32'h0);
    checkOutput("rst.s_wdata", s_if.writedata, 32'h0);
    checkOutput("rst.m0_rdata", m0_if.readdata, 32'h0);
    checkOutput("rst.m1_rdata", m1_if.readdata, 32'h0);
    checkOutput("rst.terr", 32'(timeout_err), 32'h0);

    // Single m0 read, zero wait state
    applyStimulus(0, 1,0,2'd2,32'h0, 0,0,2'd0,32'h0, 0, 32'h12345678);
    checkIdle("t1.req");
    applyStimulus(0, 1,0,2'd2,32'h0, 0,0,2'd0,32'h0, 0, 32'h12345678);
    checkOutput("t1.grant", 32'(grant), 32'h1);
    checkOutput("t1.s_read", 32'(s_if.read), 32'h1);
    checkOutput("t1.s_address", 32'(s_if.address), 32'h2);
    checkOutput("t1.m0_wait", 32'(m0_if.waitrequest), 32'h0);
    checkOutput("t1.m0_rdata", m0_if.readdata, 32'h12345678);
    checkOutput("t1.m1_wait", 32'(m1_if.waitrequest), 32'h1);
    checkOutput("t1.m1_rdata", m1_if.readdata, 32'h0);
    applyStimulus(0, 0,0,2'd0,32'h0, 0,0,2'd0,32'h0, 0, 32'h0);
    checkIdle("t1.done");

    // Simultaneous requests after reset: m0, m1, then m0, m1 again
    applyStimulus(1, 0,0,2'd0,32'h0, 0,0,2'd0,32'h0, 0, 32'h0);
    applyStimulus(0, 1,0,2'd0,32'h0, 1,0,2'd3,32'h0, 0, 32'h11111111);
    checkIdle("t2.a");
    applyStimulus(0, 1,0,2'd0,32'h0, 1,0,2'd3,32'h0, 0, 32'h11111111);
    checkOutput("t2.b.grant", 32'(grant), 32'h1);
    checkOutput("t2.b.m0_rdata", m0_if.readdata, 32'h11111111);
    checkOutput("t2.b.m1_wait", 32'(m1_if.waitrequest), 32'h1);
    applyStimulus(0, 0,0,2'd0,32'h0, 1,0,2'd3,32'h0, 0, 32'h22222222);
    checkIdle("t2.c");
    applyStimulus(0, 0,0,2'd0,32'h0, 1,0,2'd3,32'h0, 0, 32'h22222222);
    checkOutput("t2.d.grant", 32'(grant), 32'h2);
    checkOutput("t2.d.s_address", 32'(s_if.address), 32'h3);
    checkOutput("t2.d.m1_rdata", m1_if.readdata, 32'h22222222);
    checkOutput("t2.d.m0_wait", 32'(m0_if.waitrequest), 32'h1);
    // m0 asserts read and write together; the write must win
    applyStimulus(0, 1,1,2'd1,32'hC0DE0001, 1,0,2'd3,32'h0, 0, 32'h0);
    checkIdle("t2.e");
    applyStimulus(0, 1,1,2'd1,32'hC0DE0001, 1,0,2'd3,32'h0, 0, 32'h0);
    checkOutput("t2.f.grant", 32'(grant), 32'h1);
    checkOutput("t2.f.s_write", 32'(s_if.write), 32'h1);
    checkOutput("t2.f.s_read", 32'(s_if.read), 32'h0);
    checkOutput("t2.f.s_wdata", s_if.writedata, 32'hC0DE0001);
    applyStimulus(0, 0,0,2'd0,32'h0, 1,0,2'd3,32'h0, 0, 32'h33333333);
    checkIdle("t2.g");
    applyStimulus(0, 0,0,2'd0,32'h0, 1,0,2'd3,32'h0, 0, 32'h33333333);
    checkOutput("t2.h.grant", 32'(grant), 32'h2);
    applyStimulus(0, 0,0,2'd0,32'h0, 0,0,2'd0,32'h0, 0, 32'h0);
    checkIdle("t2.i");

    // m1 write with a 5-cycle slave stall; m0 arrives mid-grant and is held off
    applyStimulus(0, 0,0,2'd0,32'h0, 0,1,2'd1,32'hA5A5A5A5, 1, 32'h0);
    checkIdle("t3.a");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, (i >= 1),0,2'd0,32'h0, 0,1,2'd1,32'hA5A5A5A5, 1, 32'h0);
      checkOutput($sformatf("t3.stall%0d.grant", i), 32'(grant), 32'h2);
      checkOutput($sformatf("t3.stall%0d.s_write", i), 32'(s_if.write), 32'h1);
      checkOutput($sformatf("t3.stall%0d.s_wdata", i), s_if.writedata, 32'hA5A5A5A5);
      checkOutput($sformatf("t3.stall%0d.m1_wait", i), 32'(m1_if.waitrequest), 32'h1);
      checkOutput($sformatf("t3.stall%0d.m0_wait", i), 32'(m0_if.waitrequest), 32'h1);
    end
    applyStimulus(0, 1,0,2'd0,32'h0, 0,1,2'd1,32'hA5A5A5A5, 0, 32'h0);
    checkOutput("t3.ack.s_wdata", s_if.writedata, 32'hA5A5A5A5);
    checkOutput("t3.ack.s_address", 32'(s_if.address), 32'h1);
    checkOutput("t3.ack.m1_wait", 32'(m1_if.waitrequest), 32'h0);
    checkOutput("t3.ack.m0_wait", 32'(m0_if.waitrequest), 32'h1);
    applyStimulus(0, 1,0,2'd0,32'h0, 0,0,2'd0,32'h0, 0, 32'h0BADF00D);
    checkIdle("t3.gap");
    applyStimulus(0, 1,0,2'd0,32'h0, 0,0,2'd0,32'h0, 0, 32'h0BADF00D);
    checkOutput("t3.m0.grant", 32'(grant), 32'h1);
    checkOutput("t3.m0.rdata", m0_if.readdata, 32'h0BADF00D);
    applyStimulus(0, 0,0,2'd0,32'h0, 0,0,2'd0,32'h0, 0, 32'h0);
    checkIdle("t3.end");

    // Reset pulsed during a stalled m0 grant
    applyStimulus(0, 1,0,2'd2,32'h0, 0,0,2'd0,32'h0, 1, 32'h0);
    applyStimulus(0, 1,0,2'd2,32'h0, 0,0,2'd0,32'h0, 1, 32'h0);
    checkOutput("t4.pre.grant", 32'(grant), 32'h1);
    applyStimulus(1, 1,0,2'd2,32'h0, 0,0,2'd0,32'h0, 1, 32'h0);
    applyStimulus(0, 0,0,2'd0,32'h0, 0,0,2'd0,32'h0, 1, 32'h0);
    checkIdle("t4.post");
    checkOutput("t4.post.s_address", 32'(s_if.address), 32'h0);

    // m0 drops its read mid-stall; last owner stays m1, so m0 wins the next tie
    applyStimulus(0, 1,0,2'd0,32'h0, 0,0,2'd0,32'h0, 1, 32'h0);
    applyStimulus(0, 1,0,2'd0,32'h0, 1,0,2'd2,32'h0, 1, 32'h0);
    checkOutput("t6.b.grant", 32'(grant), 32'h1);
    applyStimulus(0, 0,0,2'd0,32'h0, 1,0,2'd2,32'h0, 1, 32'h0);
    checkOutput("t6.c.s_read", 32'(s_if.read), 32'h0);
    applyStimulus(0, 1,0,2'd0,32'h0, 1,0,2'd2,32'h0, 0, 32'hCAFE0006);
    checkIdle("t6.d");
    applyStimulus(0, 1,0,2'd0,32'h0, 1,0,2'd2,32'h0, 0, 32'hCAFE0006);
    checkOutput("t6.e.grant", 32'(grant), 32'h1);
    checkOutput("t6.e.m0_rdata", m0_if.readdata, 32'hCAFE0006);
    applyStimulus(0, 0,0,2'd0,32'h0, 1,0,2'd2,32'h0, 0, 32'h0);
    checkIdle("t6.f");
    applyStimulus(0, 0,0,2'd0,32'h0, 1,0,2'd2,32'h0, 0, 32'h0);
    checkOutput("t6.g.grant", 32'(grant), 32'h2);
    applyStimulus(0, 0,0,2'd0,32'h0, 0,0,2'd0,32'h0, 0, 32'h0);
    checkIdle("t6.h");

    // Slave never acknowledges an m0 read
    applyStimulus(0, 1,0,2'd0,32'h0, 0,0,2'd0,32'h0, 1, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1,0,2'd0,32'h0, 1,0,2'd1,32'h0, 1, 32'h0);
      checkOutput($sformatf("t5.stall%0d.grant", i), 32'(grant), 32'h1);
      checkOutput($sformatf("t5.stall%0d.m0_wait", i), 32'(m0_if.waitrequest), 32'h1);
      checkOutput($sformatf("t5.stall%0d.terr", i), 32'(timeout_err), 32'h0);
    end
`ifdef ARB_TIMEOUT_EN
    applyStimulus(0, 1,0,2'd0,32'h0, 1,0,2'd1,32'h0, 1, 32'h0);
    checkOutput("t5.abort.m0_wait", 32'(m0_if.waitrequest), 32'h0);
    checkOutput("t5.abort.m0_rdata", m0_if.readdata, 32'hDEADBEEF);
    checkOutput("t5.abort.terr", 32'(timeout_err), 32'h1);
    checkOutput("t5.abort.s_read", 32'(s_if.read), 32'h0);
    applyStimulus(0, 0,0,2'd0,32'h0, 1,0,2'd1,32'h0, 1, 32'h0);
    checkIdle("t5.after");
    checkOutput("t5.after.terr", 32'(timeout_err), 32'h0);
`else
    for (int i = 9; i <= 12; i++) begin
      applyStimulus(0, 1,0,2'd0,32'h0, 1,0,2'd1,32'h0, 1, 32'h0);
      checkOutput($sformatf("t5.hold%0d.grant", i), 32'(grant), 32'h1);
      checkOutput($sformatf("t5.hold%0d.m0_wait", i), 32'(m0_if.waitrequest), 32'h1);
      checkOutput($sformatf("t5.hold%0d.terr", i), 32'(timeout_err), 32'h0);
    end
    applyStimulus(0, 1,0,2'd0,32'h0, 1,0,2'd1,32'h0, 0, 32'h00000055);
    checkOutput("t5.ack.m0_wait", 32'(m0_if.waitrequest), 32'h0);
    checkOutput("t5.ack.m0_rdata", m0_if.readdata, 32'h00000055);
    applyStimulus(0, 0,0,2'd0,32'h0, 1,0,2'd1,32'h0, 0, 32'h0);
    checkIdle("t5.after");
`endif
    applyStimulus(0, 0,0,2'd0,32'h0, 1,0,2'd1,32'h0, 0, 32'h77777777);
    checkOutput("t5.m1.grant", 32'(grant), 32'h2);
    checkOutput("t5.m1.rdata", m1_if.readdata, 32'h77777777);
    applyStimulus(0, 0,0,2'd0,32'h0, 0,0,2'd0,32'h0, 0, 32'h0);
    checkIdle("t5.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
